// File: rtl/dec_to_bin_pkg.sv
// Shared widths and types for the 7-digit decimal-to-binary priority encoder.
package dec_to_bin_pkg;

    localparam int N_DIGITS = 7;
    localparam int BIN_W    = 4;

    typedef logic [BIN_W-1:0]  bin_code_t;
    typedef logic [N_DIGITS:1] digit_vec_t;

endpackage

// File: rtl/dec_to_bin_prio.sv
// Combinational priority encode of the digit lines: highest set index wins,
// plus any/multi flags. Bit 3 of the code stays 0 until d8/d9 exist.
module dec_to_bin_prio
    import dec_to_bin_pkg::*;
(
    input  digit_vec_t digits_i,
    output bin_code_t  code_o,
    output logic       any_o,
    output logic       multi_o
);

    always_comb begin
        code_o = '0;
        // Ascending scan so later (higher) hits overwrite lower ones.
        for (int unsigned i = 1; i <= N_DIGITS; i++) begin
            if (digits_i[3'(i)]) begin
                code_o = bin_code_t'(i);
            end
        end
    end

    assign any_o   = |digits_i;
    assign multi_o = ($countones(digits_i) > 1);

endmodule

// File: rtl/dec_to_bin.sv
// Registered 7-line decimal-digit priority encoder, one cycle of latency.
module dec_to_bin
    import dec_to_bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_d1,
    input  logic             i_d2,
    input  logic             i_d3,
    input  logic             i_d4,
    input  logic             i_d5,
    input  logic             i_d6,
    input  logic             i_d7,
    output logic [BIN_W-1:0] o_b,
    output logic             o_valid,
    output logic             o_multi
);

    digit_vec_t digits;
    bin_code_t  b_d, b_q;
    logic       valid_d, valid_q;
    logic       multi_d, multi_q;

    assign digits = {i_d7, i_d6, i_d5, i_d4, i_d3, i_d2, i_d1};

    dec_to_bin_prio u_prio (
        .digits_i (digits),
        .code_o   (b_d),
        .any_o    (valid_d),
        .multi_o  (multi_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q     <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            b_q     <= b_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign o_b     = b_q;
    assign o_valid = valid_q;
    assign o_multi = multi_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// Self-checking bench for dec_to_bin: arithmetic reference model checked every
// cycle, plus directed literal expectations from the test plan.
module tb_dec_to_bin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] vec = '0;
    logic [3:0] o_b;
    logic       o_valid, o_multi;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dec_to_bin dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d1    (vec[0]),
        .i_d2    (vec[1]),
        .i_d3    (vec[2]),
        .i_d4    (vec[3]),
        .i_d5    (vec[4]),
        .i_d6    (vec[5]),
        .i_d7    (vec[6]),
        .o_b     (o_b),
        .o_valid (o_valid),
        .o_multi (o_multi)
    );

    // Highest set digit index = ceil(log2(v+1)) for the vector read as an integer.
    function automatic int ref_code(input int v);
        return $clog2(v + 1);
    endfunction

    function automatic int ref_pop(input int v);
        int c = 0;
        while (v != 0) begin
            c += v % 2;
            v = v / 2;
        end
        return c;
    endfunction

    // Reference registers: what the outputs must hold after each edge.
    int   exp_b = 0;
    logic exp_v = 1'b0, exp_m = 1'b0;
    logic model_ok = 1'b0;

    always @(posedge clk) begin
        model_ok <= 1'b1;
        if (!rst_n) begin
            exp_b <= 0;
            exp_v <= 1'b0;
            exp_m <= 1'b0;
        end else begin
            exp_b <= ref_code(int'(vec));
            exp_v <= (vec != 0);
            exp_m <= (ref_pop(int'(vec)) >= 2);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            n_cmp++;
            if (int'(o_b) != exp_b || o_valid !== exp_v || o_multi !== exp_m) begin
                n_err++;
                $display("FAIL model t=%0t: got b=%0d v=%b m=%b expected b=%0d v=%b m=%b",
                         $time, o_b, o_valid, o_multi, exp_b, exp_v, exp_m);
            end
        end
    end

    task automatic drive(input logic [6:0] v, input logic r);
        @(negedge clk);
        vec   = v;
        rst_n = r;
    endtask

    // Check outputs just after the edge that sampled the last drive().
    task automatic lit(input string name, input int eb, input logic ev, input logic em);
        @(posedge clk);
        #1;
        n_cmp++;
        if (int'(o_b) != eb || o_valid !== ev || o_multi !== em) begin
            n_err++;
            $display("FAIL %s: got b=%0d v=%b m=%b expected b=%0d v=%b m=%b",
                     name, o_b, o_valid, o_multi, eb, ev, em);
        end
    endtask

    task automatic pin(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        pin("ref_code_d7d3", ref_code(int'(7'b1000100)), 7);
        pin("ref_code_d4",   ref_code(int'(7'b0001000)), 4);
        pin("ref_code_none", ref_code(0), 0);
        pin("ref_pop_3",     ref_pop(int'(7'b0101001)), 3);

        // Reset held two edges with d5 asserted, then release.
        drive(7'b0010000, 1'b0);
        drive(7'b0010000, 1'b0);
        lit("reset_hold", 0, 1'b0, 1'b0);
        drive(7'b0010000, 1'b1);
        lit("reset_release", 5, 1'b1, 1'b0);

        for (int i = 1; i <= 7; i++) begin
            drive(7'(1 << (i - 1)), 1'b1);
            lit($sformatf("single_d%0d", i), i, 1'b1, 1'b0);
        end
        drive('0, 1'b1);
        lit("all_low", 0, 1'b0, 1'b0);

        drive(7'b0000001, 1'b1); lit("seq_d1", 1, 1'b1, 1'b0);
        drive(7'b0000000, 1'b1); lit("seq_off1", 0, 1'b0, 1'b0);
        drive(7'b0010000, 1'b1); lit("seq_d5", 5, 1'b1, 1'b0);
        drive(7'b0000000, 1'b1); lit("seq_off2", 0, 1'b0, 1'b0);
        drive(7'b1000000, 1'b1); lit("seq_d7", 7, 1'b1, 1'b0);

        drive(7'b1000000, 1'b1); lit("prio_d7", 7, 1'b1, 1'b0);
        drive(7'b1000100, 1'b1); lit("prio_d7_d3", 7, 1'b1, 1'b1);
        drive(7'b0000100, 1'b1); lit("prio_d3", 3, 1'b1, 1'b0);

        for (int v = 0; v < 128; v++) begin
            drive(7'(v), 1'b1);
        end

        drive(7'h7F, 1'b1); lit("mid_pre", 7, 1'b1, 1'b1);
        drive(7'h7F, 1'b0); lit("mid_reset", 0, 1'b0, 1'b0);
        drive(7'h7F, 1'b1); lit("mid_post", 7, 1'b1, 1'b1);

        for (int k = 0; k < 400; k++) begin
            drive(7'($urandom_range(0, 127)), ($urandom_range(0, 15) != 0));
        end

        drive('0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
